// File: rtl/pipeline_stall_controller.sv
// Stall/flush sequencer for the 5-stage pipeline: merges ID hazards, EXE branches and
// the multi-cycle SRAM handshake into per-stage freeze/flush controls.
module pipeline_stall_controller #(
  parameter int TIMEOUT = 64,
  parameter int CNT_W   = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             hazard_detected,
  input  logic             branch_taken,
  input  logic             MEM_R_EN_MEM,
  input  logic             MEM_W_EN_MEM,
  input  logic             sram_ready,
  output logic             sram_req,
  output logic             sram_we,
  output logic             freeze_PC,
  output logic             freeze_IF_ID,
  output logic             flush_IF_ID,
  output logic             bubble_ID_EXE,
  output logic             freeze_all,
  output logic             timeout_err,
  output logic [CNT_W-1:0] stall_count
);

  typedef enum logic {RUN, MEM_WAIT} state_t;

  localparam logic [7:0] WAIT_LAST = 8'(TIMEOUT - 1);

  state_t     state, state_nxt;
  logic [7:0] wait_cnt, wait_cnt_nxt;
  logic       served, served_nxt;
  logic       timeout_set;

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    return (&v) ? v : v + CNT_W'(1);
  endfunction

  always_comb begin
    sram_req      = 1'b0;
    sram_we       = 1'b0;
    freeze_PC     = 1'b0;
    freeze_IF_ID  = 1'b0;
    flush_IF_ID   = 1'b0;
    bubble_ID_EXE = 1'b0;
    freeze_all    = 1'b0;
    state_nxt     = state;
    wait_cnt_nxt  = wait_cnt;
    served_nxt    = served;
    timeout_set   = 1'b0;
    case (state)
      RUN: begin
        // served blocks re-issuing the memory op that just completed
        served_nxt = 1'b0;
        if ((MEM_R_EN_MEM | MEM_W_EN_MEM) & ~served) begin
          sram_req     = 1'b1;
          sram_we      = MEM_W_EN_MEM;
          freeze_all   = 1'b1;
          state_nxt    = MEM_WAIT;
          wait_cnt_nxt = 8'd0;
        end else if (branch_taken) begin
          flush_IF_ID   = 1'b1;
          bubble_ID_EXE = 1'b1;
        end else if (hazard_detected) begin
          freeze_PC     = 1'b1;
          freeze_IF_ID  = 1'b1;
          bubble_ID_EXE = 1'b1;
        end
      end
      MEM_WAIT: begin
        // the ready cycle itself is unfrozen so MEM/WB captures the read data
        freeze_all   = ~sram_ready;
        wait_cnt_nxt = wait_cnt + 8'd1;
        if (sram_ready) begin
          served_nxt = 1'b1;
          state_nxt  = RUN;
        end else if (wait_cnt == WAIT_LAST) begin
          timeout_set = 1'b1;
          served_nxt  = 1'b1;
          state_nxt   = RUN;
        end
      end
      default: state_nxt = RUN;
    endcase
    if (!rst) begin
      sram_req      = 1'b0;
      sram_we       = 1'b0;
      freeze_PC     = 1'b0;
      freeze_IF_ID  = 1'b0;
      flush_IF_ID   = 1'b0;
      bubble_ID_EXE = 1'b0;
      freeze_all    = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state       <= RUN;
      wait_cnt    <= 8'd0;
      served      <= 1'b0;
      timeout_err <= 1'b0;
      stall_count <= '0;
    end else begin
      state    <= state_nxt;
      wait_cnt <= wait_cnt_nxt;
      served   <= served_nxt;
      if (timeout_set) timeout_err <= 1'b1;
      if (freeze_all | freeze_PC) stall_count <= sat_inc(stall_count);
    end
  end

endmodule

// File: tb/tb_pipeline_stall_controller.sv
// Directed bench for pipeline_stall_controller: a rule-level model checked every cycle,
// plus literal expectations at the key points of each scenario.
module tb_pipeline_stall_controller;

  localparam int TO   = 4;
  localparam int CW   = 3;
  localparam int CMAX = (1 << CW) - 1;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic hz = 1'b0, br = 1'b0, rd = 1'b0, wr = 1'b0, rdy = 1'b0;
  logic sram_req, sram_we, freeze_PC, freeze_IF_ID, flush_IF_ID, bubble_ID_EXE;
  logic freeze_all, timeout_err;
  logic [CW-1:0] stall_count;

  always #5 clk = ~clk;

  pipeline_stall_controller #(.TIMEOUT(TO), .CNT_W(CW)) dut (
    .clk(clk), .rst(rst), .hazard_detected(hz), .branch_taken(br),
    .MEM_R_EN_MEM(rd), .MEM_W_EN_MEM(wr), .sram_ready(rdy),
    .sram_req(sram_req), .sram_we(sram_we), .freeze_PC(freeze_PC),
    .freeze_IF_ID(freeze_IF_ID), .flush_IF_ID(flush_IF_ID),
    .bubble_ID_EXE(bubble_ID_EXE), .freeze_all(freeze_all),
    .timeout_err(timeout_err), .stall_count(stall_count)
  );

  int n_checks = 0;
  int n_pass   = 0;

  task automatic chk(input string nm, input int act, input int exp);
    n_checks++;
    if (act == exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d at %0t", nm, act, exp, $time);
  endtask

  // Model: "is a memory op outstanding, for how many cycles, was it just served"
  typedef struct packed {
    logic req, we, fpc, fifid, flush, bub, fall;
  } exp_t;

  bit m_mem, m_served, m_err;
  int m_waited, m_cnt;

  function automatic exp_t model_out();
    exp_t e;
    e = '0;
    if (!rst) return e;
    if (m_mem) e.fall = !rdy;
    else if ((rd || wr) && !m_served) begin
      e.req = 1'b1; e.we = wr; e.fall = 1'b1;
    end else if (br) begin
      e.flush = 1'b1; e.bub = 1'b1;
    end else if (hz) begin
      e.fpc = 1'b1; e.fifid = 1'b1; e.bub = 1'b1;
    end
    return e;
  endfunction

  always @(posedge clk or negedge rst) begin : model_upd
    exp_t e;
    if (!rst) begin
      m_mem <= 1'b0; m_served <= 1'b0; m_err <= 1'b0; m_waited <= 0; m_cnt <= 0;
    end else begin
      e = model_out();
      if ((e.fall || e.fpc) && m_cnt < CMAX) m_cnt <= m_cnt + 1;
      if (m_mem) begin
        m_waited <= m_waited + 1;
        if (rdy) begin
          m_mem <= 1'b0; m_served <= 1'b1;
        end else if (m_waited + 1 >= TO) begin
          m_mem <= 1'b0; m_served <= 1'b1; m_err <= 1'b1;
        end
      end else begin
        m_served <= 1'b0;
        if (e.req) begin
          m_mem <= 1'b1; m_waited <= 0;
        end
      end
    end
  end

  always @(negedge clk) begin : cmp
    exp_t e;
    e = model_out();
    chk("m_sram_req", int'(sram_req), int'(e.req));
    chk("m_sram_we", int'(sram_we), int'(e.we));
    chk("m_freeze_PC", int'(freeze_PC), int'(e.fpc));
    chk("m_freeze_IF_ID", int'(freeze_IF_ID), int'(e.fifid));
    chk("m_flush_IF_ID", int'(flush_IF_ID), int'(e.flush));
    chk("m_bubble_ID_EXE", int'(bubble_ID_EXE), int'(e.bub));
    chk("m_freeze_all", int'(freeze_all), int'(e.fall));
    chk("m_timeout_err", int'(timeout_err), int'(m_err));
    chk("m_stall_count", int'(stall_count), m_cnt);
  end

  task automatic set_in(input logic h, input logic b, input logic r, input logic w, input logic y);
    hz = h; br = b; rd = r; wr = w; rdy = y;
  endtask
  task automatic tick;
    @(posedge clk); #1;
  endtask
  task automatic mid;
    @(negedge clk); #1;
  endtask
  task automatic pulse_reset;
    rst = 1'b0; mid; tick; rst = 1'b1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, checks=%0d", n_checks);
    $fatal(1);
  end

  initial begin
    #1 rst = 1'b0;
    // outputs held at zero in reset even with a load present
    set_in(0, 0, 1, 0, 0);
    mid;
    chk("req_in_reset", int'(sram_req), 0);
    chk("fall_in_reset", int'(freeze_all), 0);
    tick; rst = 1'b1; set_in(0, 0, 0, 0, 0);

    // reset then idle
    repeat (10) mid;
    chk("idle_count", int'(stall_count), 0);
    chk("idle_err", int'(timeout_err), 0);
    tick;

    // load, ready three cycles after the request
    set_in(0, 0, 1, 0, 0); mid;
    chk("t2_req", int'(sram_req), 1);
    chk("t2_we", int'(sram_we), 0);
    chk("t2_fall_req", int'(freeze_all), 1);
    tick;
    for (int i = 0; i < 2; i++) begin
      mid; chk("t2_fall_wait", int'(freeze_all), 1); tick;
    end
    set_in(0, 0, 1, 0, 1); mid;
    chk("t2_fall_ready", int'(freeze_all), 0);
    tick;
    set_in(0, 0, 1, 0, 0); mid;
    chk("t2_no_reissue", int'(sram_req), 0);
    chk("t2_count", int'(stall_count), 3);
    tick;
    set_in(0, 0, 0, 0, 0);
    pulse_reset;

    // store with branch and hazard in the same cycle
    set_in(1, 1, 0, 1, 0); mid;
    chk("t3_req", int'(sram_req), 1);
    chk("t3_we", int'(sram_we), 1);
    chk("t3_fall", int'(freeze_all), 1);
    chk("t3_flush_masked", int'(flush_IF_ID), 0);
    tick;
    set_in(0, 1, 0, 1, 1); mid;
    chk("t3_fall_ready", int'(freeze_all), 0);
    chk("t3_flush_wait", int'(flush_IF_ID), 0);
    tick;
    set_in(0, 1, 0, 1, 0); mid;
    chk("t3_flush_run", int'(flush_IF_ID), 1);
    chk("t3_bubble_run", int'(bubble_ID_EXE), 1);
    chk("t3_req_served", int'(sram_req), 0);
    tick;

    // branch and hazard together in RUN
    set_in(1, 1, 0, 0, 0); mid;
    chk("t4_flush", int'(flush_IF_ID), 1);
    chk("t4_bubble", int'(bubble_ID_EXE), 1);
    chk("t4_fpc", int'(freeze_PC), 0);
    tick;
    set_in(0, 0, 0, 0, 0); mid;
    chk("t4_count", int'(stall_count), 1);
    tick;

    // hazard alone
    set_in(1, 0, 0, 0, 0); mid;
    chk("hz_fpc", int'(freeze_PC), 1);
    chk("hz_fifid", int'(freeze_IF_ID), 1);
    chk("hz_bubble", int'(bubble_ID_EXE), 1);
    tick;
    set_in(0, 0, 0, 0, 0); mid;
    chk("hz_count", int'(stall_count), 2);
    tick;

    // timeout with sram_ready never asserted
    pulse_reset;
    set_in(0, 0, 1, 0, 0); mid;
    chk("t5_req", int'(sram_req), 1);
    tick;
    for (int i = 0; i < TO; i++) begin
      mid;
      chk("t5_fall_wait", int'(freeze_all), 1);
      chk("t5_err_early", int'(timeout_err), 0);
      tick;
    end
    mid;
    chk("t5_err_set", int'(timeout_err), 1);
    chk("t5_fall_run", int'(freeze_all), 0);
    chk("t5_no_reissue", int'(sram_req), 0);
    tick;
    set_in(0, 0, 0, 0, 0);
    repeat (5) tick;
    mid;
    chk("t5_err_sticky", int'(timeout_err), 1);
    chk("t5_count", int'(stall_count), 5);
    tick;
    pulse_reset;
    mid;
    chk("t5_err_cleared", int'(timeout_err), 0);
    tick;

    // saturation, then asynchronous reset in the middle of a wait
    set_in(1, 0, 0, 0, 0);
    repeat (10) tick;
    mid;
    chk("t6_saturated", int'(stall_count), CMAX);
    tick;
    set_in(0, 0, 1, 0, 0); mid; tick;
    mid;
    chk("t6_fall_wait", int'(freeze_all), 1);
    rst = 1'b0; #1;
    chk("t6_fall_reset", int'(freeze_all), 0);
    chk("t6_count_reset", int'(stall_count), 0);
    chk("t6_req_reset", int'(sram_req), 0);
    set_in(0, 0, 0, 0, 0);
    tick; rst = 1'b1;
    mid;
    chk("t6_no_req_after", int'(sram_req), 0);
    tick;

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
